keypad_emulator: RTL
====================

# keypad_emulator

Responder side of the 4x4 keypad matrix interface: accepts a 4-bit key code over a ready/send handshake and answers the column strobes of the keypad scanner by pulling the matching row line low for a programmed number of full scans, then releasing it. Sits between test/self-test logic and the `keypad_base` scanner, in place of the physical keypad, so keystroke sequences can be injected into `keypad_input` on the same clock.

## Interface
- `HOLD_SCANS`, 8: number of complete column scans the key is held pressed (>= 1)
- `RELEASE_SCANS`, 8: number of complete scans the key is held released after the press, before `done` (>= 1)
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `key`  in  4  key code to press; sampled on accepted `send`
- `send`  in  1  request to press `key`; accepted when `ready`=1
- `ready`  out  1  high in IDLE only
- `col`  in  4  column strobe from scanner, one-hot active-low
- `row`  out  4  row response to scanner, active-low; 4'hF = no key
- `busy`  out  1  high from acceptance until `done`
- `done`  out  1  one-cycle pulse when the release phase completes

## Operation
- Key map (row r, column c), col0 leftmost: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D. Every 4-bit code is valid.
- On acceptance, `key` is latched and decoded to registered target `(tr, tc)`; later changes on `key` are ignored.
- Column pattern is valid only when exactly one `col` bit is 0. Zero or multiple low bits = invalid.
- Scan boundary: `col` registered once per cycle (`col_q`); boundary = `col`==4'b1110 and `col_q`!=4'b1110. A boundary in the cycle of reset release does not count (`col_q` resets to 4'b1110).
- States:
  - IDLE: `ready`=1, `busy`=0. `send`=1 -> SYNC, latch key.
  - SYNC: wait for a scan boundary, so the press starts on a whole scan. Boundary -> PRESS, counter := 0.
  - PRESS: `pressing`=1. Each boundary increments the counter; boundary with counter = HOLD_SCANS-1 -> RELEASE, counter := 0.
  - RELEASE: `pressing`=0. Each boundary increments; boundary with counter = RELEASE_SCANS-1 -> DONE.
  - DONE: `done`=1 for one cycle, -> IDLE.
- `row` output: `row[tr]`=0 iff `pressing`=1, `col` valid, and `col[tc]`=0; all other row bits 1. `row` is combinational from registered state and current `col` so the scanner sees the response in the same cycle it drives the column.
- Counter width: $clog2(max(HOLD_SCANS, RELEASE_SCANS))+1 bits; no wrap within a phase.
- `send` while not IDLE is ignored (not queued).
- If `col` stops changing (scanner halted), the FSM waits indefinitely in its current state; no timeout.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `row`=4'hF, state IDLE, counter 0, `col_q`=4'b1110.
- Reset mid-operation: `row` returns to 4'hF immediately (asynchronous); no `done` pulse.
- `send` accepted at edge N -> `ready`=0, `busy`=1 after edge N.
- Press asserted on the edge that detects the first boundary in SYNC; the row is then visible while column 0 is active in that same scan.
- Press lasts exactly HOLD_SCANS boundary-to-boundary scans; release lasts exactly RELEASE_SCANS scans.
- `done` high the cycle after the final release boundary; `busy` drops with `done`; `ready` returns the cycle after `done`. Back-to-back: `send` held high is accepted the cycle `ready` returns.

## Test plan
- Reset: assert `reset` mid-PRESS with key 5 and col=4'b1101 -> `row`=4'hF at once, `ready`=1, `busy`=0, no `done`.
- Single key: send key 4'h6 (r1,c2), scanner model rotating col every 4 cycles, HOLD_SCANS=2, RELEASE_SCANS=2 -> `row`=4'b1101 only while col=4'b1011, during exactly 2 scans; `done` pulse after 2 more scans; `keypad_base` reports value 6 once.
- Corner keys: keys 1, A, 0, D -> row/col pairs (0,0), (0,3), (3,0), (3,3) respectively; all other column strobes give `row`=4'hF.
- Invalid column: during PRESS drive col=4'b0000 and 4'b1100 -> `row`=4'hF; counter unchanged.
- Handshake: assert `send` with key 3 while busy -> ignored, key 6 in flight completes unchanged; `send` held high through `done` -> next key accepted the cycle `ready` returns.
- End to end: emulator feeding `keypad_input` with DIGITS=4, send 1,2,3,4 -> `out`=16'h1234.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator
// Stands in for a physical 4x4 keypad: takes a key code over a ready/send
// handshake and answers the scanner's column strobes by pulling the matching
// row low for HOLD_SCANS whole scans, then stays released for RELEASE_SCANS
// scans before pulsing done.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   key    in   [3:0] key code, sampled when send is accepted
//   send   in   press request, accepted while ready
//   ready  out  high in IDLE only
//   col    in   [3:0] scanner column strobe, one-hot active-low
//   row    out  [3:0] row response, active-low (combinational from col)
//   busy   out  high from acceptance until done
//   done   out  one-cycle pulse after the release phase
module keypad_emulator #(
  parameter int unsigned HOLD_SCANS    = 8,
  parameter int unsigned RELEASE_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       send,
  output logic       ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_SCANS = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int unsigned CNT_W     = $clog2(MAX_SCANS) + 1;
  localparam logic [3:0]  COL0      = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PRESS,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_col_q;
  logic [1:0]       r_tr;
  logic [1:0]       r_tc;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_bnd;
  logic             w_col_valid;
  logic [3:0]       w_col_n;
  logic             w_pressing;
  logic             w_accept;
  logic [3:0]       w_target;

  // Key code -> {row, col} position on the keypad face
  function automatic logic [3:0] decode_key(input logic [3:0] k);
    logic [3:0] rc;
    case (k)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'h0: rc = {2'd3, 2'd0};
      4'hF: rc = {2'd3, 2'd1};
      4'hE: rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};  // 4'hD
    endcase
    return rc;
  endfunction

  assign w_accept = (r_state == S_IDLE) && send;
  assign w_target = decode_key(key);

  // A scan starts when column 0 becomes active
  assign w_bnd = (col == COL0) && (r_col_q != COL0);

  // Valid strobe: exactly one low bit
  assign w_col_n     = ~col;
  assign w_col_valid = (w_col_n != 4'd0) && ((w_col_n & (w_col_n - 4'd1)) == 4'd0);

  assign w_pressing = (r_state == S_PRESS);

  // Same-cycle row response so the scanner sees it while it drives the column
  always_comb begin
    row = 4'hF;
    if (w_pressing && w_col_valid && !col[r_tc]) begin
      row[r_tr] = 1'b0;
    end
  end

  // State, counter and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col_q <= COL0;
      r_tr    <= 2'd0;
      r_tc    <= 2'd0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col_q <= col;
      if (w_accept) begin
        {r_tr, r_tc} <= w_target;
      end
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_SYNC) || (w_state_nxt == S_PRESS) || (w_state_nxt == S_RELEASE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state logic: phases advance only on scan boundaries
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (w_bnd) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS: begin
        if (w_bnd) begin
          if (r_cnt == CNT_W'(HOLD_SCANS - 1)) begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RELEASE: begin
        if (w_bnd) begin
          if (r_cnt == CNT_W'(RELEASE_SCANS - 1)) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
